// File: rtl/ballot_pkg.sv
// Shared types and sizing for the ballot collector and its ballot store.
package ballot_pkg;

  localparam int unsigned NUM_VOTERS = 4;
  localparam int unsigned BALLOT_W   = 2;
  localparam int unsigned VOTER_W    = 2;
  localparam int unsigned TALLY_W    = NUM_VOTERS * BALLOT_W;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    TALLY   = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/ballot_store.sv
// Per-voter ballot registers plus the "has voted" mask.
// The first ballot from a voter is kept; later ones from the same voter are ignored.
module ballot_store
  import ballot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [VOTER_W-1:0]    wr_idx,
  input  logic [BALLOT_W-1:0]   wr_data,
  output logic [NUM_VOTERS-1:0] mask,
  output logic [TALLY_W-1:0]    ballots
);

  // Write a slot only if its voter has not voted yet; clear wipes the election.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      ballots <= '0;
    end else if (clear) begin
      mask    <= '0;
      ballots <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_VOTERS; k++) begin
        if (wr_en && (wr_idx == k[VOTER_W-1:0]) && !mask[k]) begin
          ballots[k*BALLOT_W +: BALLOT_W] <= wr_data;
          mask[k]                         <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ballot_collector.sv
// Collects one ballot per voter, hands the packed ballots to an external
// combinational tally, waits TALLY_WAIT cycles, then holds the winner until
// the consumer accepts it.
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int unsigned TALLY_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  input  logic                ballot_valid,
  output logic                ballot_ready,
  input  logic [VOTER_W-1:0]  voter_id,
  input  logic [BALLOT_W-1:0] ballot,
  output logic                dup_err,
  output logic [TALLY_W-1:0]  tally_x,
  input  logic [BALLOT_W-1:0] tally_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BALLOT_W-1:0] winner
);

  state_t                state;
  state_t                state_next;
  logic [2:0]            cnt;
  logic [NUM_VOTERS-1:0] mask;
  logic [NUM_VOTERS-1:0] mask_set;
  logic                  accept;
  logic                  full_next;
  logic                  tally_done;
  logic                  clear;

  assign ballot_ready = (state == COLLECT);
  assign res_valid    = (state == HOLD);
  assign accept       = ballot_valid && ballot_ready;
  // Look ahead at the mask as it will be after this acceptance so the FSM
  // leaves COLLECT on the same edge the last slot fills, leaving no window
  // in which a fifth ballot could be accepted.
  assign mask_set     = mask | (NUM_VOTERS'(1) << voter_id);
  assign full_next    = accept && (&mask_set);
  assign tally_done   = (state == TALLY) && (cnt == 3'd1);
  assign clear        = abort || ((state == HOLD) && res_ready);

  ballot_store u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (accept && !abort),
    .wr_idx  (voter_id),
    .wr_data (ballot),
    .mask    (mask),
    .ballots (tally_x)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (full_next)  state_next = TALLY;
        TALLY:   if (tally_done) state_next = HOLD;
        HOLD:    if (res_ready)  state_next = COLLECT;
        default:                 state_next = COLLECT;
      endcase
    end
  end

  // Tally wait counter and winner capture; winner survives abort and HOLD exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      winner <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if ((state == COLLECT) && full_next) begin
      cnt <= 3'(TALLY_WAIT);
    end else if (tally_done) begin
      winner <= tally_y;
      cnt    <= '0;
    end else if (state == TALLY) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Duplicate-vote pulse, one cycle after the offending acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_err <= 1'b0;
    else        dup_err <= accept && !abort && mask[voter_id];
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench: three collectors (TALLY_WAIT 1, 3, 4) share stimulus,
// each with its own plurality tally model on tally_x/tally_y.
module tb_ballot_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       ballot_valid;
  logic [1:0] voter_id;
  logic [1:0] ballot;
  logic       res_ready;

  logic       br1, br3, br4;
  logic       de1, de3, de4;
  logic [7:0] tx1, tx3, tx4;
  logic [1:0] ty1, ty3, ty4;
  logic       rv1, rv3, rv4;
  logic [1:0] w1, w3, w4;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  // Plurality winner, lowest candidate index on ties.
  function automatic logic [1:0] tally_fn(input logic [7:0] x);
    int cnt[4];
    logic [1:0] best;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int v = 0; v < 4; v++) cnt[x[2*v +: 2]]++;
    best = 2'd0;
    for (int c = 1; c < 4; c++) if (cnt[c] > cnt[best]) best = 2'(c);
    return best;
  endfunction

  assign ty1 = tally_fn(tx1);
  assign ty3 = tally_fn(tx3);
  assign ty4 = tally_fn(tx4);

  ballot_collector #(.TALLY_WAIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .ballot_valid(ballot_valid),
    .ballot_ready(br1), .voter_id(voter_id), .ballot(ballot), .dup_err(de1),
    .tally_x(tx1), .tally_y(ty1), .res_valid(rv1), .res_ready(res_ready), .winner(w1));

  ballot_collector #(.TALLY_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .ballot_valid(ballot_valid),
    .ballot_ready(br3), .voter_id(voter_id), .ballot(ballot), .dup_err(de3),
    .tally_x(tx3), .tally_y(ty3), .res_valid(rv3), .res_ready(res_ready), .winner(w3));

  ballot_collector #(.TALLY_WAIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .ballot_valid(ballot_valid),
    .ballot_ready(br4), .voter_id(voter_id), .ballot(ballot), .dup_err(de4),
    .tally_x(tx4), .tally_y(ty4), .res_valid(rv4), .res_ready(res_ready), .winner(w4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] v, input logic [1:0] b, input logic ab);
    ballot_valid = 1'b1;
    voter_id     = v;
    ballot       = b;
    abort        = ab;
    tick();
    ballot_valid = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; ballot_valid = 1'b0;
    voter_id = '0; ballot = '0; res_ready = 1'b0;
    idle(2);
    checks++;
    if (rv1 !== 1'b0 || w1 !== 2'd0 || tx1 !== 8'h00 || de1 !== 1'b0)
      begin errors++; $display("FAIL reset_outputs rv=%b w=%0d tx=%h dup=%b want 0 0 00 0", rv1, w1, tx1, de1); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (br1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", br1); end
  endtask

  task automatic test_basic();
    logic [1:0] vals[4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    logic [7:0] x = '0;
    logic [1:0] exp;
    int hi = 0;
    bit seen = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x[2*i +: 2] = vals[i];
      send(2'(i), vals[i], 1'b0);
    end
    exp_q.push_back(tally_fn(x));
    checks++;
    if (tx1 !== 8'hE5) begin errors++; $display("FAIL basic_tally_x got %h want e5", tx1); end
    checks++;
    if (br1 !== 1'b0) begin errors++; $display("FAIL basic_ready_in_tally got %b want 0", br1); end
    for (int i = 0; i < 12; i++) begin
      if (rv1) begin
        hi++;
        if (!seen && exp_q.size() > 0) begin
          seen = 1;
          exp = exp_q.pop_front();
          checks++;
          if (w1 !== exp) begin errors++; $display("FAIL basic_winner got %0d want %0d", w1, exp); end
        end
      end
      tick();
    end
    checks++;
    if (hi != 1) begin errors++; $display("FAIL basic_res_valid_cycles got %0d want 1", hi); end
    checks++;
    if (tx1 !== 8'h00 || br1 !== 1'b1)
      begin errors++; $display("FAIL basic_after_handshake tx=%h ready=%b want 00 1", tx1, br1); end
  endtask

  task automatic test_latency();
    logic [1:0] vals[4] = '{2'd3, 2'd3, 2'd0, 2'd2};
    logic [7:0] x = '0;
    logic [1:0] exp;
    int l1 = 0;
    int l4 = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x[2*i +: 2] = vals[i];
      send(2'(i), vals[i], 1'b0);
    end
    exp = tally_fn(x);
    exp_q.push_back(exp);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rv1 && l1 == 0) begin
        l1 = i;
        if (exp_q.size() > 0) begin
          checks++;
          if (w1 !== exp_q.pop_front()) begin errors++; $display("FAIL latency_winner_w1 got %0d want %0d", w1, exp); end
        end
      end
      if (rv4 && l4 == 0) begin
        l4 = i;
        checks++;
        if (w4 !== exp) begin errors++; $display("FAIL latency_winner_w4 got %0d want %0d", w4, exp); end
      end
    end
    checks++;
    if (l1 != 1) begin errors++; $display("FAIL latency_wait1 got %0d want 1", l1); end
    checks++;
    if (l4 != 4) begin errors++; $display("FAIL latency_wait4 got %0d want 4", l4); end
    idle(2);
  endtask

  task automatic test_dup();
    send(2'd2, 2'd3, 1'b0);
    checks++;
    if (de1 !== 1'b0) begin errors++; $display("FAIL dup_first_vote got %b want 0", de1); end
    send(2'd2, 2'd0, 1'b0);
    checks++;
    if (de1 !== 1'b1) begin errors++; $display("FAIL dup_pulse got %b want 1", de1); end
    tick();
    checks++;
    if (de1 !== 1'b0) begin errors++; $display("FAIL dup_pulse_width got %b want 0", de1); end
    checks++;
    if (tx1 !== 8'h30) begin errors++; $display("FAIL dup_slot_kept got %h want 30", tx1); end
    checks++;
    if (u1.mask !== 4'b0100) begin errors++; $display("FAIL dup_mask got %b want 0100", u1.mask); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (tx1 !== 8'h00) begin errors++; $display("FAIL dup_abort_clear got %h want 00", tx1); end
  endtask

  task automatic test_hold();
    logic [1:0] vals[4] = '{2'd2, 2'd2, 2'd1, 2'd0};
    logic [7:0] x = '0;
    logic [1:0] exp = '0;
    bit seen = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x[2*i +: 2] = vals[i];
      send(2'(i), vals[i], 1'b0);
    end
    exp_q.push_back(tally_fn(x));
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rv1) seen = 1;
      else tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold_timeout res_valid=%b want 1", rv1); end
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rv1 !== 1'b1 || w1 !== exp || br1 !== 1'b0)
        begin errors++; $display("FAIL hold_stable cyc=%0d rv=%b w=%0d ready=%b want 1 %0d 0", i, rv1, w1, br1, exp); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (rv1 !== 1'b0 || br1 !== 1'b1 || tx1 !== 8'h00)
      begin errors++; $display("FAIL hold_release rv=%b ready=%b tx=%h want 0 1 00", rv1, br1, tx1); end
    checks++;
    if (w1 !== exp) begin errors++; $display("FAIL hold_winner_kept got %0d want %0d", w1, exp); end
    idle(2);
  endtask

  task automatic test_abort();
    res_ready = 1'b1;
    send(2'd0, 2'd1, 1'b0);
    send(2'd1, 2'd2, 1'b0);
    send(2'd2, 2'd3, 1'b0);
    send(2'd3, 2'd1, 1'b1);
    checks++;
    if (br1 !== 1'b1 || u1.mask !== 4'b0000 || tx1 !== 8'h00)
      begin errors++; $display("FAIL abort_clear ready=%b mask=%b tx=%h want 1 0000 00", br1, u1.mask, tx1); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rv1 !== 1'b0 || br1 !== 1'b1)
        begin errors++; $display("FAIL abort_no_tally cyc=%0d rv=%b ready=%b want 0 1", i, rv1, br1); end
    end
  endtask

  task automatic test_reset_mid_tally();
    bit rv_seen = 0;
    res_ready = 1'b1;
    send(2'd0, 2'd1, 1'b0);
    send(2'd1, 2'd1, 1'b0);
    send(2'd2, 2'd1, 1'b0);
    send(2'd3, 2'd0, 1'b0);
    tick();
    if (rv3) rv_seen = 1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rv3 !== 1'b0 || w3 !== 2'd0 || br3 !== 1'b1 || tx3 !== 8'h00)
      begin errors++; $display("FAIL rst_mid_tally rv=%b w=%0d ready=%b tx=%h want 0 0 1 00", rv3, w3, br3, tx3); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rv3) rv_seen = 1;
    end
    checks++;
    if (rv_seen || w3 !== 2'd0)
      begin errors++; $display("FAIL rst_no_result rv_seen=%b w=%0d want 0 0", rv_seen, w3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_dup();
    test_hold();
    test_abort();
    test_reset_mid_tally();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ballot_collector.md
BALLOT_COLLECTOR -- requirements
Module: ballot_collector

Interface
REQ-001 Parameter TALLY_WAIT, default 1, is the number of cycles (1..7) that tally_x is held stable before tally_y is sampled.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 abort  input  1  synchronous clear of the current election.
REQ-005 ballot_valid  input  1  ballot offered.
REQ-006 ballot_ready  output  1  collector can accept a ballot.
REQ-007 voter_id  input  2  voter index 0..3.
REQ-008 ballot  input  2  candidate index 0..3.
REQ-009 dup_err  output  1  one-cycle pulse when an accepted ballot's voter has already voted.
REQ-010 tally_x  output  8  packed ballots to the combinational 4-voter/4-candidate tally; voter k occupies bits [2k+1:2k], LSB = ballot[0].
REQ-011 tally_y  input  2  winner index returned by the tally.
REQ-012 res_valid  output  1  winner available.
REQ-013 res_ready  input  1  consumer accepts the winner.
REQ-014 winner  output  2  registered winner index.

Function
REQ-015 FSM states: COLLECT, TALLY, HOLD.
REQ-016 ballot_ready is 1 only in COLLECT, driven from state with no combinational path from ballot_valid.
REQ-017 Acceptance is ballot_valid && ballot_ready in the same cycle.
REQ-018 On acceptance with mask[voter_id]=0: store ballot in slot voter_id and set mask[voter_id].
REQ-019 On acceptance with mask[voter_id]=1: stored ballot unchanged (first vote wins), dup_err=1 next cycle for exactly one cycle.
REQ-020 When mask becomes 4'b1111, go to TALLY next cycle and load wait counter with TALLY_WAIT; no further ballots accepted.
REQ-021 tally_x always reflects the ballot registers; unvoted slots read 2'b00.
REQ-022 TALLY decrements the counter each cycle; in the cycle it reads 1, tally_y is registered into winner and state goes to HOLD (winner updates TALLY_WAIT cycles after TALLY entry).
REQ-023 res_valid=1 exactly in HOLD; winner stable while res_valid=1.
REQ-024 HOLD with res_ready=1: clear mask and ballots, go to COLLECT next cycle; res_ready outside HOLD is ignored.
REQ-025 abort=1 in any state: next cycle state=COLLECT, mask=0, ballots=0, counter=0, res_valid=0, dup_err=0; abort overrides a simultaneous ballot acceptance or result handshake.
REQ-026 winner keeps its last value after leaving HOLD until the next capture.
REQ-027 Out-of-order voter ids are legal; completion depends only on the mask.

Reset
REQ-028 rst_n=0 asynchronously forces state=COLLECT, mask=0, ballots=0, counter=0, winner=0, dup_err=0, res_valid=0.
REQ-029 After reset deassertion ballot_ready=1 on the first edge; reset mid-TALLY or mid-HOLD discards the election with no result output.

Structure
REQ-030 Shared package ballot_pkg holds the state enum, NUM_VOTERS=4, BALLOT_W=2, and the tally_x packing width (NUM_VOTERS*BALLOT_W).
REQ-031 The combinational tally stays outside this module; ballot_collector connects to it only through tally_x/tally_y.
REQ-032 One sub-module, ballot_store (4x2-bit register file plus vote mask), is instantiated; FSM and counter live in the top.

Verification
REQ-033 Voters 0..3 send ballots 1,1,2,3 with res_ready=1 and the tally model attached -> tally_x=8'hE5, res_valid for one cycle, winner equals the model output for 8'hE5.
REQ-034 Voter 2 votes 3, then voter 2 votes 0 -> dup_err pulses once, slot 2 stays 3, mask=4'b0100.
REQ-035 Full election with res_ready=0 for 10 cycles -> res_valid and winner stable for all 10 cycles, ballot_ready=0; res_ready=1 -> COLLECT and tally_x=0 next cycle.
REQ-036 abort asserted together with the fourth ballot -> no TALLY entry, mask=0, ballot_ready=1 next cycle.
REQ-037 rst_n pulled low mid-TALLY with TALLY_WAIT=3 -> immediate clear, res_valid never asserted, winner=0.
REQ-038 TALLY_WAIT=1 versus 4 -> winner captured 1 versus 4 cycles after TALLY entry.
